// File: rtl/axis_pkt_gen_pkg.sv
// Shared definitions for the AXI-Stream packet generator: FSM states,
// legal LFSR widths and their feedback tap masks.
package axis_pkt_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } gen_state_e;

  localparam int LFSR_W8  = 8;
  localparam int LFSR_W16 = 16;
  localparam int LFSR_W32 = 32;

  // Bit i set means state bit i feeds the XOR that becomes the new bit 0.
  localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_W16 = 32'h0000_D008;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  function automatic logic lfsr_width_ok(input int w);
    return (w == LFSR_W8) || (w == LFSR_W16) || (w == LFSR_W32);
  endfunction

  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] taps;
    case (w)
      LFSR_W8:  taps = TAPS_W8;
      LFSR_W16: taps = TAPS_W16;
      LFSR_W32: taps = TAPS_W32;
      default:  taps = 32'h0;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/axis_pkt_gen_lfsr.sv
// One Fibonacci LFSR step: shifts left and inserts the XOR of the tapped
// bits when advance is high, otherwise passes the state through.
module lfsr_step
  import axis_pkt_gen_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] state_i,
  input  logic         adv_i,
  output logic [W-1:0] state_o
);

  localparam logic [31:0] TAPS_ALL = lfsr_taps(W);
  localparam logic [W-1:0] TAPS = TAPS_ALL[W-1:0];

  logic fb;

  assign fb      = ^(state_i & TAPS);
  assign state_o = adv_i ? {state_i[W-2:0], fb} : state_i;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream traffic generator: emits NUM_PACKETS packets of PKT_LEN flits
// per START, and counts flits/packets arriving on the slave port.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int                 TDATAW       = 32,
  parameter int                 TDESTW       = 4,
  parameter int                 LFSR_DW      = 8,
  parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = LFSR_DW'(8'h01),
  parameter int                 NUM_PACKETS  = 4,
  parameter int                 PKT_LEN      = 4,
  parameter int                 NUM_DEST     = 1,
  parameter int                 DEST_BASE    = 0,
  parameter int                 GAP_CYCLES   = 0,
  parameter int                 MODE         = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TDESTW-1:0] AXIS_M_TDEST,
  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TDESTW-1:0] AXIS_S_TDEST,
  output logic              BUSY,
  output logic              DONE,
  output logic [15:0]       RX_FLITS,
  output logic [15:0]       RX_PKTS,
  output logic [TDATAW-1:0] RX_LAST_DATA
);

  if (!lfsr_width_ok(LFSR_DW) || (TDATAW < LFSR_DW) || (LFSR_DEFAULT == '0) ||
      (NUM_PACKETS < 1) || (PKT_LEN < 1) || (NUM_DEST < 1) ||
      (NUM_DEST > (1 << TDESTW)) || (GAP_CYCLES < 0) ||
      !((MODE == 0) || (MODE == 1))) begin : g_param_err
    $error("axis_pkt_gen: illegal parameter combination");
  end

  localparam logic [31:0] PKT_LAST  = 32'(PKT_LEN - 1);
  localparam logic [31:0] PKTS_LAST = 32'(NUM_PACKETS - 1);
  localparam logic [31:0] DEST_LAST = 32'(NUM_DEST - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] DEST_OFS  = 32'(DEST_BASE);

  gen_state_e          state_q, state_d;
  logic [LFSR_DW-1:0]  lfsr_q, lfsr_d, lfsr_nxt;
  logic [TDATAW-1:0]   cnt_q, cnt_d;
  logic [31:0]         flit_q, flit_d, pkt_q, pkt_d, gap_q, gap_d, dsel_q, dsel_d;
  logic [31:0]         dsum;
  logic                restart, m_acc, s_acc;

  logic                m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic [TDATAW-1:0]   m_tdata_q, m_tdata_d;
  logic [TDESTW-1:0]   m_tdest_q, m_tdest_d;
  logic                busy_q, busy_d, done_q, done_d, s_tready_q;
  logic [15:0]         rx_flits_q, rx_pkts_q;
  logic [TDATAW-1:0]   rx_last_q;
  logic                unused_sink;

  // Master handshake: a flit transfers on a rising edge where TVALID and
  // TREADY are both high; while TVALID is high without TREADY every
  // payload register holds its value.
  assign m_acc = m_tvalid_q & AXIS_M_TREADY;
  assign s_acc = AXIS_S_TVALID & s_tready_q;

  lfsr_step #(.W(LFSR_DW)) u_lfsr (
    .state_i (lfsr_q),
    .adv_i   (m_acc),
    .state_o (lfsr_nxt)
  );

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_nxt;
    cnt_d   = cnt_q;
    flit_d  = flit_q;
    pkt_d   = pkt_q;
    gap_d   = gap_q;
    dsel_d  = dsel_q;
    restart = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_SEND;
          restart = 1'b1;
        end
      end
      ST_SEND: begin
        if (m_acc) begin
          cnt_d = cnt_q + 1'b1;
          if (flit_q == PKT_LAST) begin
            flit_d = 32'd0;
            if (pkt_q == PKTS_LAST) begin
              state_d = ST_DONE;
            end else begin
              pkt_d  = pkt_q + 32'd1;
              dsel_d = (dsel_q == DEST_LAST) ? 32'd0 : dsel_q + 32'd1;
              if (GAP_CYCLES > 0) begin
                state_d = ST_GAP;
                gap_d   = 32'd0;
              end
            end
          end else begin
            flit_d = flit_q + 32'd1;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 32'd1;
        if (gap_q == GAP_LAST) state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart) begin
      lfsr_d = LFSR_DEFAULT;
      cnt_d  = '0;
      flit_d = 32'd0;
      pkt_d  = 32'd0;
      gap_d  = 32'd0;
      dsel_d = 32'd0;
    end
  end

  // Outputs are computed from next-state values so they register cleanly.
  assign dsum       = DEST_OFS + dsel_d;
  assign m_tvalid_d = (state_d == ST_SEND);
  assign m_tlast_d  = (flit_d == PKT_LAST);
  assign m_tdata_d  = (MODE == 1) ? cnt_d : TDATAW'(lfsr_d);
  assign m_tdest_d  = dsum[TDESTW-1:0];
  assign busy_d     = (state_d == ST_SEND) || (state_d == ST_GAP);
  assign done_d     = (state_d == ST_DONE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LFSR_DEFAULT;
      cnt_q      <= '0;
      flit_q     <= 32'd0;
      pkt_q      <= 32'd0;
      gap_q      <= 32'd0;
      dsel_q     <= 32'd0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      m_tdest_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s_tready_q <= 1'b0;
      rx_flits_q <= 16'd0;
      rx_pkts_q  <= 16'd0;
      rx_last_q  <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      flit_q     <= flit_d;
      pkt_q      <= pkt_d;
      gap_q      <= gap_d;
      dsel_q     <= dsel_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      m_tdest_q  <= m_tdest_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s_tready_q <= 1'b1;
      if (s_acc) begin
        rx_last_q <= AXIS_S_TDATA;
        if (rx_flits_q != 16'hFFFF) rx_flits_q <= rx_flits_q + 16'd1;
        if (AXIS_S_TLAST && (rx_pkts_q != 16'hFFFF)) rx_pkts_q <= rx_pkts_q + 16'd1;
      end
    end
  end

  assign AXIS_M_TVALID = m_tvalid_q;
  assign AXIS_M_TLAST  = m_tlast_q;
  assign AXIS_M_TDATA  = m_tdata_q;
  assign AXIS_M_TDEST  = m_tdest_q;
  assign AXIS_S_TREADY = s_tready_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign RX_FLITS      = rx_flits_q;
  assign RX_PKTS       = rx_pkts_q;
  assign RX_LAST_DATA  = rx_last_q;

  // Destination of received flits is not tracked.
  assign unused_sink = ^{AXIS_S_TDEST, dsum};

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- TDATAW, 32: AXI-Stream data width.
- TDESTW, 4: destination width.
- LFSR_DW, 8: LFSR width; only 8, 16 or 32 are legal, with TDATAW >= LFSR_DW.
- LFSR_DEFAULT, 8'h01: LFSR seed; must be nonzero.
- NUM_PACKETS, 4: packets per run; must be at least 1.
- PKT_LEN, 4: flits per packet; must be at least 1.
- NUM_DEST, 1: number of destinations rotated over; range 1..2^TDESTW.
- DEST_BASE, 0: first destination.
- GAP_CYCLES, 0: idle cycles between packets.
- MODE, 0: 0 selects LFSR data, 1 selects counter data.

REQ-002 Ports (name, direction, width, meaning), one per line:
- CLK, in, 1: single clock.
- RST_N, in, 1: synchronous active-low reset.
- START, in, 1: run request pulse.
- AXIS_M_TVALID, out, 1; AXIS_M_TREADY, in, 1; AXIS_M_TDATA, out, TDATAW; AXIS_M_TLAST, out, 1; AXIS_M_TDEST, out, TDESTW: AXI-Stream master toward the NoC.
- AXIS_S_TVALID, in, 1; AXIS_S_TREADY, out, 1; AXIS_S_TDATA, in, TDATAW; AXIS_S_TLAST, in, 1; AXIS_S_TDEST, in, TDESTW: AXI-Stream slave from the NoC.
- BUSY, out, 1: run in progress.
- DONE, out, 1: run complete.
- RX_FLITS, out, 16: received flit count.
- RX_PKTS, out, 16: received packet count.
- RX_LAST_DATA, out, TDATAW: data of the last received flit.

REQ-003 The block has one clock and reset is synchronous and active-low; the clock port is CLK and the reset port is RST_N.

Function
REQ-004 The FSM has four states: IDLE, SEND, GAP, DONE; reset enters IDLE.
REQ-005 IDLE transitions to SEND on the cycle after START=1; START is ignored in SEND and GAP.
REQ-006 DONE transitions to SEND on START=1, clearing the packet and flit counters and reseeding the LFSR to LFSR_DEFAULT.
REQ-007 AXIS_M_TVALID is 1 only in SEND; a flit is accepted on a cycle where TVALID and TREADY are both 1.
REQ-008 While TVALID=1 and TREADY=0, TDATA, TDEST and TLAST hold stable and TVALID stays 1.
REQ-009 MODE=0: TDATA is the LFSR state zero-extended to TDATAW.
REQ-010 The LFSR advances only on acceptance, using next = {s[LFSR_DW-2:0], fb}.
REQ-011 LFSR feedback taps: width 8 uses s7^s5^s4^s3; width 16 uses s15^s14^s12^s3; width 32 uses s31^s21^s1^s0.
REQ-012 MODE=1: TDATA is a TDATAW-bit count of accepted flits in the run, starting at 0 and wrapping modulo 2^TDATAW.
REQ-013 TDEST = (DEST_BASE + (packet index mod NUM_DEST)) mod 2^TDESTW, constant for all flits of a packet.
REQ-014 TLAST=1 exactly on flit index PKT_LEN-1 of each packet; with PKT_LEN=1 every flit carries TLAST.
REQ-015 When the last flit of a packet is accepted and packets remain: if GAP_CYCLES>0, go to GAP for exactly GAP_CYCLES cycles with TVALID=0, then SEND; otherwise stay in SEND with no bubble.
REQ-016 When the last flit of packet NUM_PACKETS-1 is accepted, go to DONE the next cycle.
REQ-017 BUSY=1 in SEND and GAP; DONE=1 in the DONE state only.
REQ-018 AXIS_S_TREADY is 1 whenever not in reset, independent of FSM state.
REQ-019 On each slave handshake: RX_FLITS increments, saturating at 16'hFFFF; RX_LAST_DATA captures TDATA; RX_PKTS increments on TLAST=1, saturating at 16'hFFFF.
REQ-020 Receive counters are not cleared by START.
REQ-021 Simultaneous master and slave handshakes are fully independent.

Reset
REQ-022 While RST_N=0 at a clock edge, the block resets:
- FSM enters IDLE; LFSR loads LFSR_DEFAULT; all counters clear.
- Every output is 0: AXIS_M_TVALID, AXIS_M_TLAST, AXIS_M_TDATA, AXIS_M_TDEST, AXIS_S_TREADY, BUSY, DONE, RX_FLITS, RX_PKTS, RX_LAST_DATA.
REQ-023 Reset mid-packet abandons the packet; no partial packet is resumed after reset.

Structure
REQ-024 LFSR tap masks per width, the FSM state enum and the legal-width constants live in the shared parameters package.
REQ-025 The LFSR is a separate sub-module, lfsr_step, with ports state in, advance enable, and state out.
REQ-026 Illegal parameter values cause an elaboration-time error.

Verification
REQ-027 MODE=0, LFSR_DEFAULT=8'h01, PKT_LEN=4, NUM_PACKETS=2, NUM_DEST=2, DEST_BASE=1, TREADY=1, one START pulse:
- Packet 0 is 01,02,04,08 with TLAST on 08 and TDEST=1.
- Packet 1 begins with 11, has TDEST=2, and follows packet 0 with no bubble.
- DONE=1 after the 8th flit.
REQ-028 Same as REQ-027 with TREADY held 0 for 3 cycles on flit 2 → TDATA=04 held stable for those cycles, no flit lost or duplicated.
REQ-029 GAP_CYCLES=2 → exactly 2 cycles with TVALID=0 between TLAST of packet 0 and flit 0 of packet 1.
REQ-030 MODE=1, PKT_LEN=1, NUM_PACKETS=3, then START again in DONE:
- First run: data 0,1,2, TLAST on every flit.
- Second run: data restarts at 0.
REQ-031 Slave side drives 5 flits with TLAST on flits 3 and 5, the last flit carrying TDATA=32'hCAFE → RX_FLITS=5, RX_PKTS=2, RX_LAST_DATA=32'hCAFE.
REQ-032 RST_N=0 for one cycle mid-packet → all outputs 0 the next cycle; the next START resends from seed 01.
